// File: rtl/prio_arb_reg.sv
// Registered N-channel arbiter: captures the winning channel's data into a one-word output
// holding register, with fixed-priority or round-robin selection and a capture counter.
module prio_arb_reg #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned CW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*DW-1:0] din,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [CW-1:0]      out_ch,
  output logic [N_CH-1:0]    gnt,
  output logic [15:0]        gnt_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e        state_q;
  logic [CW-1:0] last_q;
  logic [CW-1:0] win;
  logic          capture;

  // Scan from the far end so the nearest candidate is the one left standing.
  always_comb begin
    win = '0;
    if (MODE == 0) begin
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
        if (req[i]) win = CW'(i);
      end
    end else begin
      for (int k = int'(N_CH); k >= 1; k--) begin
        int idx;
        idx = (int'(last_q) + k) % int'(N_CH);
        if (req[idx]) win = CW'(idx);
      end
    end
  end

  // In IDLE out_ready is irrelevant; in HOLD a new word may replace the old one only on accept.
  assign capture = (|req) && ((state_q == StIdle) || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= CW'(N_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      gnt       <= '0;
      gnt_cnt   <= '0;
    end else if (capture) begin
      state_q   <= StHold;
      last_q    <= win;
      out_valid <= 1'b1;
      out_data  <= din[DW*int'(win) +: DW];
      out_ch    <= win;
      gnt       <= N_CH'(1) << win;
      gnt_cnt   <= gnt_cnt + 16'd1;
    end else begin
      gnt <= '0;
      if (state_q == StHold && out_ready) begin
        state_q   <= StIdle;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_arb_reg.sv
// Bench for prio_arb_reg: one fixed-priority and one round-robin instance on shared stimulus,
// checked every cycle against a behavioural model plus literal scenario checks.
module tb_prio_arb_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic        out_ready = 1'b0;

  logic        v0, v1;
  logic [7:0]  d0, d1;
  logic [1:0]  c0, c1;
  logic [3:0]  g0, g1;
  logic [15:0] n0, n1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prio_arb_reg #(.N_CH(4), .DW(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(v0), .out_data(d0), .out_ch(c0), .gnt(g0), .gnt_cnt(n0)
  );

  prio_arb_reg #(.N_CH(4), .DW(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(v1), .out_data(d1), .out_ch(c1), .gnt(g1), .gnt_cnt(n1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: index 0 is the fixed-priority instance, index 1 the round-robin one.
  logic        m_v[2];
  logic [7:0]  m_d[2];
  int          m_c[2];
  logic [3:0]  m_g[2];
  logic [15:0] m_n[2];
  int          m_last[2];

  function automatic int pick(input int mode, input logic [3:0] r, input int last);
    if (mode == 0) begin
      for (int c = 0; c < 4; c++) if (r[c]) return c;
    end else begin
      for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_v[m] <= 1'b0; m_d[m] <= '0; m_c[m] <= 0; m_g[m] <= '0; m_n[m] <= '0; m_last[m] <= 3;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if ((|req) && (!m_v[m] || out_ready)) begin
          m_v[m]    <= 1'b1;
          m_c[m]    <= pick(m, req, m_last[m]);
          m_d[m]    <= din[8*pick(m, req, m_last[m]) +: 8];
          m_g[m]    <= 4'b0001 << pick(m, req, m_last[m]);
          m_n[m]    <= m_n[m] + 16'd1;
          m_last[m] <= pick(m, req, m_last[m]);
        end else begin
          m_g[m] <= '0;
          if (out_ready) m_v[m] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("fp.valid", v0, m_v[0]); chk("fp.data", d0, m_d[0]); chk("fp.ch", c0, m_c[0]);
    chk("fp.gnt", g0, m_g[0]);   chk("fp.cnt", n0, m_n[0]);
    chk("rr.valid", v1, m_v[1]); chk("rr.data", d1, m_d[1]); chk("rr.ch", c1, m_c[1]);
    chk("rr.gnt", g1, m_g[1]);   chk("rr.cnt", n1, m_n[1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1, so the pulse sits wholly between clock edges.
  task automatic pulse_rst();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst.valid", {v1, v0}, 2'b00);
    chk("rst.cnt", {n1, n0}, 32'h0);
    chk("rst.gnt", {g1, g0}, 8'h00);
    chk("rst.data", {d1, d0}, 16'h0000);
    #9 rst_n = 1'b1;

    // Fixed priority: lowest requester wins every cycle; round-robin alternates.
    req = 4'b1010; din = 32'h3300_1100; out_ready = 1'b1;
    step();
    chk("fp1.valid", v0, 1); chk("fp1.ch", c0, 1); chk("fp1.data", d0, 8'h11);
    chk("fp1.gnt", g0, 4'b0010); chk("rr1.ch", c1, 1);
    step();
    chk("fp2.ch", c0, 1); chk("fp2.gnt", g0, 4'b0010); chk("fp2.cnt", n0, 2);
    chk("rr2.ch", c1, 3); chk("rr2.data", d1, 8'h33);

    // Round-robin rotation from reset.
    pulse_rst();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr.seq", c1, exp_seq[i]);
      chk("fp.seq", c0, 0);
    end
    chk("rr.cnt5", n1, 5);

    // Backpressure holds the word and blocks capture.
    pulse_rst();
    req = 4'b0100; din = 32'h00A5_0000; out_ready = 1'b1;
    step();
    chk("bp.cap", c0, 2);
    out_ready = 1'b0; req = 4'b0001; din = 32'h0000_005A;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.data", d0, 8'hA5); chk("bp.ch", c0, 2);
      chk("bp.gnt", g0, 0); chk("bp.cnt", n0, 1); chk("bp.rrch", c1, 2);
    end
    out_ready = 1'b1;
    step();
    chk("bp.rel.ch", c0, 0); chk("bp.rel.data", d0, 8'h5A); chk("bp.rel.cnt", n0, 2);
    chk("bp.rel.rrch", c1, 0);

    // Drain keeps the last word on the data bus.
    req = 4'b0000;
    step();
    chk("drain.valid", v0, 0); chk("drain.gnt", g0, 0); chk("drain.data", d0, 8'h5A);

    // Reset mid-HOLD takes effect without a clock.
    req = 4'b1111;
    step();
    chk("hold.valid", v1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.valid", {v1, v0}, 2'b00);
    chk("arst.cnt", {n1, n0}, 32'h0);
    #1 rst_n = 1'b1;
    step();
    chk("arst.rr.first", c1, 0); chk("arst.rr.cnt", n1, 1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      req = 4'($urandom) & 4'($urandom);
      din = $urandom;
      out_ready = ($urandom % 4) != 0;
      step();
      if ($urandom % 64 == 0) pulse_rst();
    end

    // Counter wrap.
    pulse_rst();
    req = 4'b0001; out_ready = 1'b1;
    repeat (65535) step();
    chk("wrap.ffff", n0, 16'hFFFF);
    step();
    chk("wrap.zero", n0, 16'h0000);
    chk("wrap.rrzero", n1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_arb_reg.md
PRIO_ARB_REG -- requirements
Module: prio_arb_reg

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of request channels (legal range 2..8).
REQ-002 SHALL have parameter DW, default 8, data width per channel.
REQ-003 SHALL have parameter MODE, default 0, arbitration mode (0 = fixed priority, channel 0 highest; 1 = round-robin).
REQ-004 SHALL derive CW = max(1, clog2(N_CH)), the channel index width.
REQ-005 SHALL have port clk  input  1  clock, rising-edge active.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  N_CH  per-channel request level.
REQ-008 SHALL have port din  input  N_CH*DW  per-channel data; channel k occupies bits [k*DW +: DW].
REQ-009 SHALL have port out_ready  input  1  downstream accept.
REQ-010 SHALL have port out_valid  output  1  out_data/out_ch hold a captured word.
REQ-011 SHALL have port out_data  output  DW  captured data of the winning channel.
REQ-012 SHALL have port out_ch  output  CW  index of the winning channel.
REQ-013 SHALL have port gnt  output  N_CH  one-hot grant pulse, one cycle per capture.
REQ-014 SHALL have port gnt_cnt  output  16  total captures since reset, wraps at 0xFFFF -> 0x0000.

Function
REQ-015 SHALL register all outputs; there is no combinational path from inputs to outputs.
REQ-016 SHALL implement two states, IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-017 IDLE: when |req=1 at a clock edge, capture the winner w: out_data<=din[w], out_ch<=w, gnt<=onehot(w), out_valid<=1, gnt_cnt+=1, go to HOLD; when |req=0, stay in IDLE with gnt<=0.
REQ-018 HOLD with out_ready=0: out_data, out_ch and out_valid hold, gnt<=0, and no capture occurs regardless of req.
REQ-019 HOLD with out_ready=1 and |req=1: capture a new winner in the same edge (back-to-back, one word per cycle) and stay in HOLD.
REQ-020 HOLD with out_ready=1 and |req=0: out_valid<=0, gnt<=0, go to IDLE; out_data and out_ch keep their last values.
REQ-021 MODE=0: the winner is the lowest-index asserted req bit.
REQ-022 MODE=1: search starts at (last+1) mod N_CH and wraps upward; last<=w on every capture.
REQ-023 MODE=1: when only the last-granted channel requests, that channel wins again.
REQ-024 The capture data SHALL be din sampled at the capture edge; din is don't-care otherwise.
REQ-025 gnt SHALL be high exactly in the cycle after a capture edge; gnt=0 in all other cycles.
REQ-026 out_ready while out_valid=0 SHALL be ignored.
REQ-027 Requesters SHALL see their grant via gnt only; req is not cleared by the block, so a held req re-arbitrates.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, out_valid=0, out_data=0, out_ch=0, gnt=0, gnt_cnt=0, last=N_CH-1 (round-robin starts at channel 0).
REQ-029 Reset asserted mid-HOLD SHALL discard the held word; no grant pulse and no count increment occur.
REQ-030 After rst_n deasserts, the first capture SHALL be allowed on the first rising clk edge.

Verification (N_CH=4, DW=8)
REQ-031 MODE=0: req=4'b1010, din ch1=0x11, ch3=0x33, out_ready=1 -> next cycle out_valid=1, out_ch=1, out_data=0x11, gnt=4'b0010; req unchanged -> ch1 wins every cycle.
REQ-032 MODE=1: req=4'b1111 held, out_ready=1 for 5 cycles -> out_ch sequence 0,1,2,3,0; gnt_cnt=5.
REQ-033 Backpressure: capture ch2 (data 0xA5), then out_ready=0 for 3 cycles with req=4'b0001 -> out_data=0xA5, out_ch=2 stable, gnt=0, gnt_cnt unchanged; out_ready=1 -> ch0 captured next cycle.
REQ-034 Drain: HOLD, out_ready=1, req=0 -> next cycle out_valid=0, gnt=0, out_data retains its last value.
REQ-035 Reset mid-HOLD: rst_n=0 between edges -> out_valid=0, gnt_cnt=0 immediately without a clock; MODE=1 first capture after release with req=4'b1111 -> ch0.
REQ-036 Counter wrap: force 0xFFFF captures (or preload via a bench backdoor) -> the next capture gives gnt_cnt=0x0000.
